// File: rtl/mac_feeder.sv
// Operand-pair feeder for a MAC: buffers {weight, activation} pairs through a load port and
// streams them onto a shared tri-state bus with valid/ready handshaking.
module mac_feeder #(
   parameter int unsigned word_size         = 8,
   parameter int unsigned breadth           = 8,
   parameter int unsigned address_bus_width = 4,
   parameter int unsigned bus_width         = 2 * word_size
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         start,
   input  logic [address_bus_width-1:0] len,
   input  logic                         wr_en,
   input  logic [address_bus_width-1:0] wr_addr,
   input  logic [word_size-1:0]         wr_wt,
   input  logic [word_size-1:0]         wr_x,
   input  logic                         bus_ready,
   inout  wire  [bus_width-1:0]         bus,
   output logic                         bus_valid,
   output logic                         busy,
   output logic                         done,
   output logic                         wr_err
);

   localparam int unsigned ptr_w = (breadth > 1) ? $clog2(breadth) : 1;
   localparam logic [address_bus_width-1:0] breadth_n = address_bus_width'(breadth);

   typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

   state_e                         state_q, state_d;
   logic [address_bus_width-1:0]   idx_q, idx_d;
   logic [address_bus_width-1:0]   n_q, n_d;
   logic                           wr_err_q, wr_err_d;
   logic                           wr_ok;
   logic [ptr_w-1:0]               rd_idx;

   logic [word_size-1:0] wt_buff [breadth];
   logic [word_size-1:0] x_buff  [breadth];

   // Writes are only legal while the stream is not reading the buffers.
   assign wr_ok    = wr_en && (state_q == StIdle || state_q == StDone)
                     && (32'(wr_addr) < breadth);
   assign wr_err_d = wr_en && !wr_ok;
   assign wr_err   = wr_err_q;
   assign rd_idx   = idx_q[ptr_w-1:0];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      busy      = (state_q == StStream) || (state_q == StDrain);
      bus_valid = (state_q == StStream) && en;
      done      = (state_q == StDone);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               n_d     = (len > breadth_n) ? breadth_n : len;
               idx_d   = '0;
               state_d = (n_d == '0) ? StDone : StStream;
            end
         end
         StStream: begin
            if (bus_valid && bus_ready) begin
               // Index stops at n-1; the last transfer leaves it there rather than wrapping.
               if (idx_q + 1'b1 == n_q) state_d = StDrain;
               else                      idx_d   = idx_q + 1'b1;
            end
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         n_q      <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         n_q      <= n_d;
         wr_err_q <= wr_err_d;
      end
   end

   // Buffer storage carries no reset; contents are don't-care until loaded.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         wt_buff[wr_addr[ptr_w-1:0]] <= wr_wt;
         x_buff[wr_addr[ptr_w-1:0]]  <= wr_x;
      end
   end

   assign bus = bus_valid ? bus_width'({wt_buff[rd_idx], x_buff[rd_idx]}) : {bus_width{1'bz}};

endmodule
